// File: rtl/RISCV_pkg.sv
// Shared RISC-V decode types for the immediate generator.
//   imm_fmt_t    : immediate format reported alongside each decoded word
//   opcode_t     : major opcodes recognised by the decoder (base set plus
//                  JALR, LUI and AUIPC)
//   skid_state_t : occupancy of the two-entry output skid buffer
package RISCV_pkg;

  // FMT_NONE must stay encoded as zero: the pipeline clears its output
  // register with '0 on reset and relies on that reading as FMT_NONE.
  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_R    = 3'd1,
    FMT_I    = 3'd2,
    FMT_S    = 3'd3,
    FMT_B    = 3'd4,
    FMT_U    = 3'd5,
    FMT_J    = 3'd6
  } imm_fmt_t;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OP_IMM = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111
  } opcode_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder for RV32I/RV64I instruction words.
//   instruction : raw 32-bit instruction word
//   imm         : immediate, sign-extended from its MSB to XLEN (0 for R and
//                 unrecognised opcodes)
//   fmt         : immediate format of the opcode
//   illegal     : opcode not in the recognised set
// XLEN is meant to be 32 or 64.
module imm_decode
  import RISCV_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instruction,
  output logic [XLEN-1:0] imm,
  output imm_fmt_t        fmt,
  output logic            illegal
);

  // Every base-ISA immediate fits in 32 bits once sign-extended, so build it
  // at 32 bits signed and let the final size cast extend to XLEN.
  logic signed [31:0] imm32;

  always_comb begin
    imm32   = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    case (instruction[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        fmt   = FMT_I;
        imm32 = {{20{instruction[31]}}, instruction[31:20]};
      end
      OPC_STORE: begin
        fmt   = FMT_S;
        imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      end
      OPC_BRANCH: begin
        fmt   = FMT_B;
        imm32 = {{19{instruction[31]}}, instruction[31], instruction[7],
                 instruction[30:25], instruction[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt   = FMT_U;
        imm32 = {instruction[31:12], 12'b0};
      end
      OPC_JAL: begin
        fmt   = FMT_J;
        imm32 = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                 instruction[20], instruction[30:21], 1'b0};
      end
      OPC_OP: begin
        fmt   = FMT_R;
        imm32 = '0;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  assign imm = XLEN'(imm32);

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator with a two-entry skid buffer.
// Each accepted instruction/pc pair is decoded on the way in; the result
// (immediate, pc + immediate, format, illegal flag) is registered and shown
// on the outputs one cycle later.
//   clk, rst          : clock, asynchronous active-low reset
//   flush             : discard all held entries (and any same-cycle offer)
//   in_valid/in_ready : input handshake; instruction, pc ride with it
//   out_valid/out_ready : output handshake; imm, target, fmt, illegal ride with it
//   illegal_cnt       : saturating count of accepted illegal words
//   dbg_state         : skid buffer occupancy
//
// Handshake: a word moves across an interface on a rising edge where valid
// and ready are both 1. A producer holding valid keeps its payload stable
// until it is taken; out_valid is never withdrawn and the output payload
// never changes while out_ready is 0. in_ready is a flop (state != TWO for
// the coming cycle), so it has no combinational dependence on out_ready.
module imm_gen_pipe
  import RISCV_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instruction,
  input  logic [XLEN-1:0]  pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic [XLEN-1:0]  target,
  output imm_fmt_t         fmt,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt,
  output skid_state_t      dbg_state
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    imm_fmt_t        fmt;
    logic            illegal;
  } entry_t;

  logic [XLEN-1:0] dec_imm;
  imm_fmt_t        dec_fmt;
  logic            dec_illegal;
  entry_t          in_entry;

  skid_state_t     state_q, state_d;
  entry_t          out_q, out_d;
  entry_t          skid_q, skid_d;
  logic            in_ready_q;
  logic [CNT_W-1:0] cnt_q;

  logic accept;
  logic drain;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instruction (instruction),
    .imm         (dec_imm),
    .fmt         (dec_fmt),
    .illegal     (dec_illegal)
  );

  // Illegal words decode to imm = 0, so their target is simply pc.
  // The adder wraps at XLEN bits by construction.
  always_comb begin
    in_entry         = '0;
    in_entry.imm     = dec_imm;
    in_entry.target  = pc + dec_imm;
    in_entry.fmt     = dec_fmt;
    in_entry.illegal = dec_illegal;
  end

  // A word offered during flush is neither stored nor counted.
  assign accept = in_valid && in_ready_q && !flush;
  assign drain  = (state_q != ST_EMPTY) && out_ready;

  // out_q is the visible head; skid_q only ever holds the word behind it.
  // In TWO in_ready_q is 0, so no accept can arrive there.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_ONE;
          out_d   = in_entry;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          out_d = in_entry;
        end else if (accept) begin
          state_d = ST_TWO;
          skid_d  = in_entry;
        end else if (drain) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (drain) begin
          state_d = ST_ONE;
          out_d   = skid_q;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_EMPTY;
      out_q      <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != ST_TWO);
    end
  end

  // Counts accepted words only; flush leaves the count alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (accept && dec_illegal && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (state_q != ST_EMPTY);
  assign imm         = out_q.imm;
  assign target      = out_q.target;
  assign fmt         = out_q.fmt;
  assign illegal     = out_q.illegal;
  assign illegal_cnt = cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: one 32-bit instance with a 2-bit counter
// and one 64-bit instance with the default counter, driven by the same
// stimulus. Inputs change and outputs are sampled on the falling clock edge.
module tb_imm_gen_pipe;
  import RISCV_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] instruction;
  logic [63:0] pc;
  logic [31:0] pc32;

  logic        in_ready_a, out_valid_a, illegal_a;
  logic [31:0] imm_a, target_a;
  imm_fmt_t    fmt_a;
  logic [1:0]  cnt_a;
  skid_state_t st_a;

  logic        in_ready_b, out_valid_b, illegal_b;
  logic [63:0] imm_b, target_b;
  imm_fmt_t    fmt_b;
  logic [15:0] cnt_b;
  skid_state_t st_b;

  int vectors    = 0;
  int miscompares = 0;
  int exp_cnt_b  = 0;
  logic [31:0] exp_q[$];

  assign pc32 = pc[31:0];

  // clock/reset block
  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .CNT_W(2)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .instruction(instruction), .pc(pc32), .out_valid(out_valid_a), .out_ready(out_ready),
    .imm(imm_a), .target(target_a), .fmt(fmt_a), .illegal(illegal_a),
    .illegal_cnt(cnt_a), .dbg_state(st_a)
  );

  imm_gen_pipe #(.XLEN(64), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .instruction(instruction), .pc(pc), .out_valid(out_valid_b), .out_ready(out_ready),
    .imm(imm_b), .target(target_b), .fmt(fmt_b), .illegal(illegal_b),
    .illegal_cnt(cnt_b), .dbg_state(st_b)
  );

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instruction = 32'h0; pc = 64'h0;
    repeat (2) @(negedge clk);
    vectors++; if (out_valid_a !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %0b want 0", out_valid_a); end
    vectors++; if (in_ready_a !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready: got %0b want 0", in_ready_a); end
    vectors++; if (imm_a !== 32'h0) begin miscompares++; $display("FAIL rst_imm: got %h want 0", imm_a); end
    vectors++; if (target_a !== 32'h0) begin miscompares++; $display("FAIL rst_target: got %h want 0", target_a); end
    vectors++; if (fmt_a !== FMT_NONE) begin miscompares++; $display("FAIL rst_fmt: got %0d want %0d", fmt_a, FMT_NONE); end
    vectors++; if (illegal_a !== 1'b0) begin miscompares++; $display("FAIL rst_illegal: got %0b want 0", illegal_a); end
    vectors++; if (cnt_a !== 2'd0) begin miscompares++; $display("FAIL rst_cnt: got %0d want 0", cnt_a); end
    vectors++; if (st_a !== ST_EMPTY) begin miscompares++; $display("FAIL rst_state: got %0d want %0d", st_a, ST_EMPTY); end
    vectors++; if (out_valid_b !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid_64: got %0b want 0", out_valid_b); end
    rst = 1'b1;
    #1;
    vectors++; if (in_ready_a !== 1'b0) begin miscompares++; $display("FAIL rel_in_ready_before_edge: got %0b want 0", in_ready_a); end
    @(negedge clk);
    vectors++; if (in_ready_a !== 1'b1) begin miscompares++; $display("FAIL rel_in_ready_after_edge: got %0b want 1", in_ready_a); end
    vectors++; if (in_ready_b !== 1'b1) begin miscompares++; $display("FAIL rel_in_ready_after_edge_64: got %0b want 1", in_ready_b); end
  endtask

  // Five illegal words through a 2-bit counter: 1, 2, 3, 3, 3.
  task automatic test_illegal_count();
    pc = 64'h200; instruction = 32'h0000_007F; in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      vectors++; if (cnt_a !== ((k > 3) ? 2'd3 : 2'(k))) begin miscompares++; $display("FAIL cnt_sat[%0d]: got %0d want %0d", k, cnt_a, (k > 3) ? 3 : k); end
      vectors++; if (cnt_b !== 16'(k)) begin miscompares++; $display("FAIL cnt_wide[%0d]: got %0d want %0d", k, cnt_b, k); end
      vectors++; if (imm_a !== 32'h0) begin miscompares++; $display("FAIL ill_imm[%0d]: got %h want 0", k, imm_a); end
      vectors++; if (illegal_a !== 1'b1) begin miscompares++; $display("FAIL ill_flag[%0d]: got %0b want 1", k, illegal_a); end
      vectors++; if (fmt_a !== FMT_NONE) begin miscompares++; $display("FAIL ill_fmt[%0d]: got %0d want %0d", k, fmt_a, FMT_NONE); end
      vectors++; if (target_a !== 32'h200) begin miscompares++; $display("FAIL ill_target[%0d]: got %h want 00000200", k, target_a); end
    end
    exp_cnt_b = 5;
    in_valid = 1'b0;
    @(negedge clk);
    vectors++; if (out_valid_a !== 1'b0) begin miscompares++; $display("FAIL ill_drained: got %0b want 0", out_valid_a); end
  endtask

  // addi x1,x0,-4 at pc 0x100, one-cycle latency.
  task automatic test_addi();
    pc = 64'h100; instruction = 32'hFFC0_0093; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    vectors++; if (out_valid_a !== 1'b1) begin miscompares++; $display("FAIL addi_valid: got %0b want 1", out_valid_a); end
    vectors++; if (imm_a !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL addi_imm: got %h want fffffffc", imm_a); end
    vectors++; if (target_a !== 32'h0000_00FC) begin miscompares++; $display("FAIL addi_target: got %h want 000000fc", target_a); end
    vectors++; if (fmt_a !== FMT_I) begin miscompares++; $display("FAIL addi_fmt: got %0d want %0d", fmt_a, FMT_I); end
    vectors++; if (imm_b !== 64'hFFFF_FFFF_FFFF_FFFC) begin miscompares++; $display("FAIL addi_imm_64: got %h want fffffffffffffffc", imm_b); end
    vectors++; if (target_b !== 64'h0000_0000_0000_00FC) begin miscompares++; $display("FAIL addi_target_64: got %h want 00000000000000fc", target_b); end
    @(negedge clk);
    vectors++; if (out_valid_a !== 1'b0) begin miscompares++; $display("FAIL addi_drained: got %0b want 0", out_valid_a); end
  endtask

  // lui x1,0x80000 on the 64-bit instance.
  task automatic test_lui64();
    pc = 64'h4000; instruction = 32'h8000_00B7; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    vectors++; if (imm_b !== 64'hFFFF_FFFF_8000_0000) begin miscompares++; $display("FAIL lui_imm_64: got %h want ffffffff80000000", imm_b); end
    vectors++; if (fmt_b !== FMT_U) begin miscompares++; $display("FAIL lui_fmt_64: got %0d want %0d", fmt_b, FMT_U); end
    vectors++; if (target_b !== 64'hFFFF_FFFF_8000_4000) begin miscompares++; $display("FAIL lui_target_64: got %h want ffffffff80004000", target_b); end
    vectors++; if (imm_a !== 32'h8000_0000) begin miscompares++; $display("FAIL lui_imm_32: got %h want 80000000", imm_a); end
    @(negedge clk);
  endtask

  // Back-to-back stream of hand-encoded words covering every format.
  task automatic test_formats();
    logic [31:0] tv_instr [12];
    logic [63:0] tv_pc    [12];
    logic [63:0] tv_imm   [12];
    imm_fmt_t    tv_fmt   [12];
    logic        tv_ill   [12];
    logic [63:0] exp_t64;
    logic [31:0] exp_t32;
    tv_instr[0]  = 32'hFE51_2C23; tv_pc[0]  = 64'h1000; tv_imm[0]  = 64'hFFFF_FFFF_FFFF_FFF8; tv_fmt[0]  = FMT_S;    tv_ill[0]  = 1'b0; // sw x5,-8(x2)
    tv_instr[1]  = 32'hFE00_0EE3; tv_pc[1]  = 64'h1000; tv_imm[1]  = 64'hFFFF_FFFF_FFFF_FFFC; tv_fmt[1]  = FMT_B;    tv_ill[1]  = 1'b0; // beq -4
    tv_instr[2]  = 32'h0000_0863; tv_pc[2]  = 64'h1000; tv_imm[2]  = 64'h10;                  tv_fmt[2]  = FMT_B;    tv_ill[2]  = 1'b0; // beq +16
    tv_instr[3]  = 32'h0010_00EF; tv_pc[3]  = 64'h1000; tv_imm[3]  = 64'h800;                 tv_fmt[3]  = FMT_J;    tv_ill[3]  = 1'b0; // jal x1,+2048
    tv_instr[4]  = 32'h8000_006F; tv_pc[4]  = 64'h1000; tv_imm[4]  = 64'hFFFF_FFFF_FFF0_0000; tv_fmt[4]  = FMT_J;    tv_ill[4]  = 1'b0; // jal x0,-1MiB
    tv_instr[5]  = 32'h1234_5097; tv_pc[5]  = 64'h1000; tv_imm[5]  = 64'h1234_5000;           tv_fmt[5]  = FMT_U;    tv_ill[5]  = 1'b0; // auipc x1
    tv_instr[6]  = 32'h7FF1_2083; tv_pc[6]  = 64'h1000; tv_imm[6]  = 64'h7FF;                 tv_fmt[6]  = FMT_I;    tv_ill[6]  = 1'b0; // lw x1,2047(x2)
    tv_instr[7]  = 32'hFFF0_8067; tv_pc[7]  = 64'h1000; tv_imm[7]  = 64'hFFFF_FFFF_FFFF_FFFF; tv_fmt[7]  = FMT_I;    tv_ill[7]  = 1'b0; // jalr x0,-1(x1)
    tv_instr[8]  = 32'h0031_00B3; tv_pc[8]  = 64'h1000; tv_imm[8]  = 64'h0;                   tv_fmt[8]  = FMT_R;    tv_ill[8]  = 1'b0; // add x1,x2,x3
    tv_instr[9]  = 32'h0000_007F; tv_pc[9]  = 64'h1000; tv_imm[9]  = 64'h0;                   tv_fmt[9]  = FMT_NONE; tv_ill[9]  = 1'b1;
    tv_instr[10] = 32'h0000_0000; tv_pc[10] = 64'h1000; tv_imm[10] = 64'h0;                   tv_fmt[10] = FMT_NONE; tv_ill[10] = 1'b1;
    tv_instr[11] = 32'h0200_0093; tv_pc[11] = 64'hFFFF_FFFF_FFFF_FFF0; tv_imm[11] = 64'h20;  tv_fmt[11] = FMT_I;    tv_ill[11] = 1'b0; // target wraps
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      instruction = tv_instr[i]; pc = tv_pc[i];
      exp_t64 = tv_pc[i] + tv_imm[i];
      exp_t32 = tv_pc[i][31:0] + tv_imm[i][31:0];
      if (tv_ill[i]) exp_cnt_b++;
      @(negedge clk);
      vectors++; if (out_valid_a !== 1'b1 || in_ready_a !== 1'b1) begin miscompares++; $display("FAIL fmt_hs[%0d]: got valid=%0b ready=%0b want 1/1", i, out_valid_a, in_ready_a); end
      vectors++; if (imm_a !== tv_imm[i][31:0]) begin miscompares++; $display("FAIL fmt_imm[%0d]: got %h want %h", i, imm_a, tv_imm[i][31:0]); end
      vectors++; if (target_a !== exp_t32) begin miscompares++; $display("FAIL fmt_target[%0d]: got %h want %h", i, target_a, exp_t32); end
      vectors++; if (fmt_a !== tv_fmt[i]) begin miscompares++; $display("FAIL fmt_fmt[%0d]: got %0d want %0d", i, fmt_a, tv_fmt[i]); end
      vectors++; if (illegal_a !== tv_ill[i]) begin miscompares++; $display("FAIL fmt_illegal[%0d]: got %0b want %0b", i, illegal_a, tv_ill[i]); end
      vectors++; if (imm_b !== tv_imm[i]) begin miscompares++; $display("FAIL fmt_imm_64[%0d]: got %h want %h", i, imm_b, tv_imm[i]); end
      vectors++; if (target_b !== exp_t64) begin miscompares++; $display("FAIL fmt_target_64[%0d]: got %h want %h", i, target_b, exp_t64); end
    end
    in_valid = 1'b0;
    @(negedge clk);
    vectors++; if (cnt_b !== 16'(exp_cnt_b)) begin miscompares++; $display("FAIL fmt_cnt_64: got %0d want %0d", cnt_b, exp_cnt_b); end
  endtask

  // A, B, C offered against a stalled consumer, then released.
  task automatic test_back_to_back();
    out_ready = 1'b0; pc = 64'h10;
    instruction = 32'h0010_0093; in_valid = 1'b1; exp_q.push_back(32'h1); // A
    @(negedge clk);
    vectors++; if (in_ready_a !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_one: got %0b want 1", in_ready_a); end
    instruction = 32'h0020_0093; exp_q.push_back(32'h2); // B
    @(negedge clk);
    vectors++; if (st_a !== ST_TWO) begin miscompares++; $display("FAIL b2b_state_two: got %0d want %0d", st_a, ST_TWO); end
    vectors++; if (in_ready_a !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_two: got %0b want 0", in_ready_a); end
    vectors++; if (imm_a !== 32'h1) begin miscompares++; $display("FAIL b2b_head_a: got %h want 00000001", imm_a); end
    instruction = 32'h0030_0093; exp_q.push_back(32'h3); // C, held off
    @(negedge clk);
    vectors++; if (in_ready_a !== 1'b0) begin miscompares++; $display("FAIL b2b_c_held: got %0b want 0", in_ready_a); end
    vectors++; if (imm_a !== exp_q.pop_front()) begin miscompares++; $display("FAIL b2b_a_stable: got %h want 00000001", imm_a); end
    out_ready = 1'b1;
    @(negedge clk);
    vectors++; if (out_valid_a !== 1'b1 || imm_a !== exp_q.pop_front()) begin miscompares++; $display("FAIL b2b_beat_b: got valid=%0b imm=%h want 1/00000002", out_valid_a, imm_a); end
    vectors++; if (target_a !== 32'h12) begin miscompares++; $display("FAIL b2b_target_b: got %h want 00000012", target_a); end
    vectors++; if (in_ready_a !== 1'b1 || st_a !== ST_ONE) begin miscompares++; $display("FAIL b2b_back_to_one: got ready=%0b state=%0d want 1/%0d", in_ready_a, st_a, ST_ONE); end
    @(negedge clk);
    in_valid = 1'b0;
    vectors++; if (out_valid_a !== 1'b1 || imm_a !== exp_q.pop_front()) begin miscompares++; $display("FAIL b2b_beat_c: got valid=%0b imm=%h want 1/00000003", out_valid_a, imm_a); end
    @(negedge clk);
    vectors++; if (out_valid_a !== 1'b0 || exp_q.size() != 0) begin miscompares++; $display("FAIL b2b_end: got valid=%0b pending=%0d want 0/0", out_valid_a, exp_q.size()); end
  endtask

  // Flush from TWO while an illegal word is offered.
  task automatic test_flush();
    out_ready = 1'b0; pc = 64'h20;
    instruction = 32'h0010_0093; in_valid = 1'b1;
    @(negedge clk);
    instruction = 32'h0020_0093;
    @(negedge clk);
    vectors++; if (st_a !== ST_TWO) begin miscompares++; $display("FAIL flush_pre_two: got %0d want %0d", st_a, ST_TWO); end
    flush = 1'b1; instruction = 32'h0000_007F;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    vectors++; if (out_valid_a !== 1'b0) begin miscompares++; $display("FAIL flush_valid: got %0b want 0", out_valid_a); end
    vectors++; if (in_ready_a !== 1'b1) begin miscompares++; $display("FAIL flush_ready: got %0b want 1", in_ready_a); end
    vectors++; if (st_a !== ST_EMPTY) begin miscompares++; $display("FAIL flush_state: got %0d want %0d", st_a, ST_EMPTY); end
    vectors++; if (cnt_b !== 16'(exp_cnt_b)) begin miscompares++; $display("FAIL flush_cnt: got %0d want %0d", cnt_b, exp_cnt_b); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++; if (out_valid_a !== 1'b0) begin miscompares++; $display("FAIL flush_quiet[%0d]: got %0b want 0", i, out_valid_a); end
    end
    instruction = 32'h0090_0093; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    vectors++; if (out_valid_a !== 1'b1 || imm_a !== 32'h9 || illegal_a !== 1'b0) begin miscompares++; $display("FAIL flush_next_word: got valid=%0b imm=%h ill=%0b want 1/00000009/0", out_valid_a, imm_a, illegal_a); end
    @(negedge clk);
  endtask

  // Reset asserted in TWO, checked before any clock edge.
  task automatic test_reset_mid();
    out_ready = 1'b0; pc = 64'h30;
    instruction = 32'h0010_0093; in_valid = 1'b1;
    @(negedge clk);
    instruction = 32'h0020_0093;
    @(negedge clk);
    in_valid = 1'b0;
    vectors++; if (st_a !== ST_TWO) begin miscompares++; $display("FAIL rmid_pre_two: got %0d want %0d", st_a, ST_TWO); end
    #2 rst = 1'b0;
    #1;
    vectors++; if (out_valid_a !== 1'b0) begin miscompares++; $display("FAIL rmid_valid: got %0b want 0", out_valid_a); end
    vectors++; if (st_a !== ST_EMPTY) begin miscompares++; $display("FAIL rmid_state: got %0d want %0d", st_a, ST_EMPTY); end
    vectors++; if (in_ready_a !== 1'b0 || imm_a !== 32'h0) begin miscompares++; $display("FAIL rmid_regs: got ready=%0b imm=%h want 0/00000000", in_ready_a, imm_a); end
    vectors++; if (cnt_b !== 16'h0) begin miscompares++; $display("FAIL rmid_cnt: got %0d want 0", cnt_b); end
    exp_cnt_b = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin miscompares++; $display("FAIL rmid_release: got ready=%0b valid=%0b want 1/0", in_ready_a, out_valid_a); end
    pc = 64'h300; instruction = 32'h0050_0093; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    vectors++; if (out_valid_a !== 1'b1 || imm_a !== 32'h5 || target_a !== 32'h305) begin miscompares++; $display("FAIL rmid_first_word: got valid=%0b imm=%h target=%h want 1/00000005/00000305", out_valid_a, imm_a, target_a); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_illegal_count();
    test_addi();
    test_lui64();
    test_formats();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 and 64 only.
REQ-002 SHALL have parameter CNT_W, default 16, width of the illegal-instruction counter.
REQ-003 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port flush, input, 1, synchronous discard of all held entries.
REQ-006 SHALL have port in_valid, input, 1, instruction/pc pair offered.
REQ-007 SHALL have port in_ready, output, 1, block can accept this cycle.
REQ-008 SHALL have port instruction, input, 32, raw RV32I/RV64I instruction word.
REQ-009 SHALL have port pc, input, XLEN, address of the instruction.
REQ-010 SHALL have port out_valid, output, 1, result held on outputs.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts this cycle.
REQ-012 SHALL have port imm, output, XLEN, signed sign-extended immediate.
REQ-013 SHALL have port target, output, XLEN, pc + imm modulo 2^XLEN.
REQ-014 SHALL have port fmt, output, imm_fmt_t, decoded immediate format.
REQ-015 SHALL have port illegal, output, 1, unrecognised opcode flag.
REQ-016 SHALL have port illegal_cnt, output, CNT_W, saturating count of accepted illegal words.

Function
REQ-017 Opcode map: 0010011, 0000011, and 1100111 (JALR) SHALL use FMT_I; 0100011 FMT_S; 1100011 FMT_B; 0110111 and 0010111 FMT_U; 1101111 FMT_J; 0110011 FMT_R with imm=0.
REQ-018 I: instruction[31:20]; S: {[31:25],[11:7]}; B: {[31],[7],[30:25],[11:8],0}; J: {[31],[19:12],[20],[30:21],0}; U: {[31:12],12'b0}. Each SHALL be sign-extended from its MSB to XLEN.
REQ-019 Any other opcode SHALL give illegal=1, fmt=FMT_NONE, imm=0, target=pc.
REQ-020 Transfer in SHALL occur when in_valid&&in_ready, and transfer out when out_valid&&out_ready.
REQ-021 Latency SHALL be one cycle: an accepted word appears on the outputs the next cycle when the output register is empty or draining.
REQ-022 Storage SHALL be a 2-entry skid buffer with states EMPTY, ONE, and TWO.
REQ-023 In EMPTY, in_ready SHALL be 1; on accept the state SHALL go to ONE.
REQ-024 In ONE, in_ready SHALL be 1: accept with no drain goes to TWO; accept with drain stays ONE; drain with no accept goes to EMPTY.
REQ-025 In TWO, in_ready SHALL be 0: on drain the skid entry SHALL move to the output and the state SHALL go to ONE.
REQ-026 in_ready SHALL be driven from a register (state!=TWO), with no combinational path from out_ready.
REQ-027 Outputs SHALL remain stable while out_valid&&!out_ready.
REQ-028 Word order SHALL be preserved; no word may be lost or duplicated.
REQ-029 flush SHALL force EMPTY next cycle and take priority over a same-cycle accept or drain.
REQ-030 A word offered in a flush cycle SHALL be dropped and SHALL NOT be counted.
REQ-031 illegal_cnt SHALL increment once per accepted illegal word, saturate at all-ones, and be unaffected by flush.
REQ-032 Target addition SHALL wrap modulo 2^XLEN with no overflow flag.

Reset
REQ-033 While rst=0, the block SHALL hold state EMPTY, out_valid=0, in_ready=0, imm=0, target=0, fmt=FMT_NONE, illegal=0, and illegal_cnt=0.
REQ-034 in_ready SHALL rise on the first clk edge after rst deasserts.
REQ-035 Reset mid-transfer SHALL discard all entries asynchronously.

Structure
REQ-036 imm_fmt_t (FMT_NONE, FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J) and the extended opcode_t (adding JALR, LUI, AUIPC) SHALL reside in RISCV_pkg.
REQ-037 A combinational sub-module imm_decode (instruction -> imm, fmt, illegal; parameter XLEN) SHALL be instantiated once, at the input side, feeding the skid and output registers.

Verification
REQ-038 XLEN=32, pc=0x100, instruction 0xFFC00093 (addi x1,x0,-4) -> next cycle imm=0xFFFFFFFC, target=0x000000FC, fmt=FMT_I.
REQ-039 XLEN=64, instruction 0x800000B7 (lui x1,0x80000) -> imm=0xFFFFFFFF80000000, fmt=FMT_U.
REQ-040 out_ready=0, three back-to-back offers A,B,C -> A held on outputs, B in skid, in_ready=0, C held off; out_ready=1 -> A, B, C delivered in order with one beat each.
REQ-041 State TWO plus flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the dropped word never appears.
REQ-042 CNT_W=2, five accepted words with opcode 0x7F -> illegal_cnt reads 1, 2, 3, 3, 3, and each result has imm=0.
REQ-043 rst asserted while in state TWO -> out_valid=0 immediately without a clk edge; after release the first accepted word appears with latency 1.
